scratchpad_rr_arbiter: RTL and testbench
========================================

Name: scratchpad_rr_arbiter

Overview:
- Shares the single scratchpad SRAM interface (one write port, one read port, 1-cycle read latency) among NUM_REQ compute engines, e.g. the Q/K/V/score MAC sequencers.
- Performs round-robin arbitration with burst locking, a forced-release fairness limit, and per-requester read-return tagging.
- Sits between the engine FSMs and the top-level scratchpad SRAM ports.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 16, SRAM address width
DATA_W, 32, SRAM data width
MAX_BURST, 16, maximum beats per grant before forced release (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a beat (or wants the bus)
req_we  in  NUM_REQ  1 = write beat, 0 = read beat
req_last  in  NUM_REQ  beat is the final beat of requester's burst
req_addr  in  NUM_REQ*ADDR_W  flattened; slice i = [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data, same slicing
req_ready  out  NUM_REQ  one-hot grant; beat accepted when req_valid[i] & req_ready[i]
rd_valid  out  NUM_REQ  one-hot; read data for requester i is on rd_data this cycle
rd_data  out  DATA_W  read return data, passthrough of sram_read_data
busy  out  1  arbiter in BURST state
owner_id  out  $clog2(NUM_REQ)  current owner index (0 when idle)
sram_write_enable  out  1  scratchpad write enable
sram_write_address  out  ADDR_W  scratchpad write address
sram_write_data  out  DATA_W  scratchpad write data
sram_read_address  out  ADDR_W  scratchpad read address
sram_read_data  in  DATA_W  scratchpad read data, valid 1 cycle after read address

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
  - req_ready=0, rd_valid=0, busy=0, owner_id=0.
  - All sram_* outputs = 0.
  - Reset mid-burst abandons the burst and drops any in-flight read return; rd_valid=0 the cycle after the reset edge.
- IDLE:
  - req_ready=0. If any req_valid is high, owner <= first index i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Then beat_cnt <= 0 and state <= BURST. Otherwise stay in IDLE.
- BURST:
  - req_ready[owner]=1, all other req_ready bits 0, busy=1.
  - Accepted beat with req_we=1: sram_write_enable=1, write address/data = owner's addr/wdata, same cycle (combinational mux from the owner slice).
  - Accepted beat with req_we=0: sram_read_address = owner's addr, same cycle.
  - The owner may idle (req_valid=0) while holding the grant: no SRAM op that cycle, no beat counted.
- Release:
  - Triggered by an accepted beat with req_last=1, or by an accepted beat where beat_cnt == MAX_BURST-1 (forced, regardless of req_last).
  - On release: state <= IDLE, rr_ptr <= (owner+1) mod NUM_REQ. Otherwise beat_cnt increments on each accepted beat.
  - A forcibly released requester keeps req_valid high and re-arbitrates from IDLE.
- Latency:
  - req_valid rising in IDLE to req_ready: 1 cycle.
  - Every release costs exactly one IDLE cycle.
  - Steady-state throughput is 1 beat/cycle within a burst.
- Read return:
  - rd_pend and rd_tag are registered on each accepted read beat. Next cycle: rd_valid[rd_tag]=1 and rd_data = sram_read_data.
  - A read accepted on the releasing beat still returns to its issuer the next cycle, even if that cycle is IDLE.
- Idle SRAM outputs:
  - With no accepted write beat, sram_write_enable=0 and write address/data=0.
  - Read address holds its last driven value; no read is implied.
- Write and read in the same cycle cannot occur: one beat per cycle.
- Ports with no requesters (req_valid all 0) never leave IDLE.

Decomposition:
- Package scratchpad_arb_pkg holds:
  - typedef enum logic [0:0] {ARB_IDLE, ARB_BURST} arb_state_e;
  - function clog2-safe OWNER_W;
  - default constants for NUM_REQ, ADDR_W, DATA_W and MAX_BURST.
- Sub-module rr_pick (combinational): inputs req vector and rr_ptr; outputs a grant index plus a found flag. Implemented with a double-width rotate-and-priority-encode.
- The FSM, beat counter, read-tag pipeline and SRAM muxing stay in the top module.

Test Plan:
- Single requester:
  - Stimulus: req 2 issues 3 writes to addr 0x10..0x12 with data 0xA,0xB,0xC, last on beat 3.
  - Required: ready high 1 cycle after valid; 3 consecutive sram_write_enable pulses with matching address/data; busy drops; rr_ptr=3.
- Read return:
  - Stimulus: req 1 reads addr 0x20, SRAM model returns 0xDEADBEEF.
  - Required: rd_valid=0b0010 and rd_data=0xDEADBEEF exactly 1 cycle after the accepted beat; no other rd_valid bit set.
- Round-robin fairness:
  - Stimulus: reqs 0,1,3 each continuously valid with single-beat bursts (last=1).
  - Required: grant order 0,1,3,0,1,3; each grant separated by one IDLE cycle.
- Forced release:
  - Stimulus: req 0 issues 40 beats with req_last never set while req 2 waits.
  - Required: req 0 is released after beat 16; req 2 is granted next; req 0 is regranted after req 2 releases.
- Owner stall:
  - Stimulus: owner drops req_valid for 3 cycles mid-burst.
  - Required: grant held, no SRAM ops, beat_cnt unchanged, burst resumes.
- Reset mid-burst:
  - Stimulus: reset asserted during beat 5 of a read burst.
  - Required: next cycle all outputs are 0, state IDLE, the pending rd_valid is suppressed, and arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/scratchpad_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scratchpad_arb_pkg
// Description : Shared types, default constants and width helper for the
//               scratchpad round-robin arbiter and its pick sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
package scratchpad_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_BURST = 16;

    // Index width that never collapses to zero bits for tiny requester counts.
    function automatic int OWNER_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : scratchpad_arb_pkg
`default_nettype wire

// File: rtl/scratchpad_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Finds the first set bit of
//               i_req starting at i_rr_ptr and wrapping modulo NUM_REQ.
// Ports       : i_req       - request vector
//               i_rr_ptr    - highest-priority index for this search
//               o_grant_idx - winning index (valid when o_found)
//               o_found     - at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import scratchpad_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = OWNER_W(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_found
);

    logic [NUM_REQ-1:0] w_rot;
    logic [IDX_W-1:0]   w_off;
    logic [IDX_W:0]     w_sum;

    // Doubling the vector turns the rotate into a plain right shift: bit 0
    // of the result is the request at i_rr_ptr, bit k is at i_rr_ptr+k.
    assign w_rot = NUM_REQ'({i_req, i_req} >> i_rr_ptr);

    always_comb begin
        w_off = '0;
        // Descending scan so the lowest rotated offset wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDX_W'(k);
            end
        end
    end

    assign o_found     = |w_rot;
    assign w_sum       = {1'b0, i_rr_ptr} + {1'b0, w_off};
    assign o_grant_idx = IDX_W'((w_sum >= (IDX_W+1)'(NUM_REQ))
                                ? (w_sum - (IDX_W+1)'(NUM_REQ)) : w_sum);

endmodule : rr_pick
`default_nettype wire

// File: rtl/scratchpad_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : scratchpad_rr_arbiter
// Description : Shares one scratchpad SRAM (1 write port, 1 read port with a
//               1-cycle read latency) among NUM_REQ engines. Round-robin
//               grant, burst locking, forced release after MAX_BURST beats,
//               and per-requester tagging of read returns.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               req_valid/we/last   - per-requester beat qualifiers
//               req_addr/req_wdata  - flattened per-requester address/data
//               req_ready           - one-hot grant to the burst owner
//               rd_valid/rd_data    - tagged read return
//               busy/owner_id       - burst in progress / current owner
//               sram_*              - scratchpad SRAM interface
// Revision    : 1.0 - initial release
// ============================================================================
module scratchpad_rr_arbiter
    import scratchpad_arb_pkg::*;
#(
    parameter  int NUM_REQ   = DEF_NUM_REQ,
    parameter  int ADDR_W    = DEF_ADDR_W,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int OW        = OWNER_W(NUM_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy,
    output logic [OW-1:0]             owner_id,
    output logic                      sram_write_enable,
    output logic [ADDR_W-1:0]         sram_write_address,
    output logic [DATA_W-1:0]         sram_write_data,
    output logic [ADDR_W-1:0]         sram_read_address,
    input  logic [DATA_W-1:0]         sram_read_data
);

    arb_state_e         r_state;
    logic [OW-1:0]      r_rr_ptr;
    logic [OW-1:0]      r_owner;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_rd_pend;
    logic [OW-1:0]      r_rd_tag;
    logic [ADDR_W-1:0]  r_rd_addr_hold;

    logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];
    logic [ADDR_W-1:0]  w_own_addr;
    logic [DATA_W-1:0]  w_own_wdata;
    logic               w_busy;
    logic               w_accept;
    logic               w_wr_beat;
    logic               w_rd_beat;
    logic               w_release;
    logic [OW-1:0]      w_pick_idx;
    logic               w_pick_found;
    logic [OW-1:0]      w_next_ptr;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req       (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant_idx (w_pick_idx),
        .o_found     (w_pick_found)
    );

    assign w_busy      = (r_state == ARB_BURST);
    assign w_own_addr  = w_addr_arr[r_owner];
    assign w_own_wdata = w_wdata_arr[r_owner];
    assign w_accept    = w_busy & req_valid[r_owner];
    assign w_wr_beat   = w_accept &  req_we[r_owner];
    assign w_rd_beat   = w_accept & ~req_we[r_owner];
    // Last beat of the burst, or the beat that exhausts the fairness budget.
    assign w_release   = w_accept &
                         (req_last[r_owner] | (r_beat_cnt == CNT_W'(MAX_BURST - 1)));
    assign w_next_ptr  = (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ARB_IDLE;
            r_rr_ptr       <= '0;
            r_owner        <= '0;
            r_beat_cnt     <= '0;
            r_rd_pend      <= 1'b0;
            r_rd_tag       <= '0;
            r_rd_addr_hold <= '0;
        end else begin
            // Read-return tag tracks the issuer even across the release beat.
            r_rd_pend <= w_rd_beat;
            if (w_rd_beat) begin
                r_rd_tag       <= r_owner;
                r_rd_addr_hold <= w_own_addr;
            end

            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_found) begin
                        r_owner    <= w_pick_idx;
                        r_beat_cnt <= '0;
                        r_state    <= ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    if (w_release) begin
                        r_state  <= ARB_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end else if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        rd_valid  = '0;
        if (w_busy) begin
            req_ready[r_owner] = 1'b1;
        end
        if (r_rd_pend) begin
            rd_valid[r_rd_tag] = 1'b1;
        end
    end

    assign rd_data            = r_rd_pend ? sram_read_data : '0;
    assign busy               = w_busy;
    assign owner_id           = w_busy ? r_owner : '0;
    assign sram_write_enable  = w_wr_beat;
    assign sram_write_address = w_wr_beat ? w_own_addr  : '0;
    assign sram_write_data    = w_wr_beat ? w_own_wdata : '0;
    // The read port keeps its last address between reads.
    assign sram_read_address  = w_rd_beat ? w_own_addr : r_rd_addr_hold;

endmodule : scratchpad_rr_arbiter
`default_nettype wire

// File: tb/tb_scratchpad_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_scratchpad_rr_arbiter
// Description : Self-checking bench for scratchpad_rr_arbiter: directed
//               scenarios followed by randomized traffic, compared cycle by
//               cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scratchpad_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MB = 16;
    localparam int OW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_we, req_last;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rd_valid;
    logic [DW-1:0]   rd_data;
    logic            busy;
    logic [OW-1:0]   owner_id;
    logic            sram_write_enable;
    logic [AW-1:0]   sram_write_address, sram_read_address;
    logic [DW-1:0]   sram_write_data, sram_read_data;

    scratchpad_rr_arbiter #(
        .NUM_REQ (N), .ADDR_W (AW), .DATA_W (DW), .MAX_BURST (MB)
    ) dut (
        .clk (clk), .reset (reset),
        .req_valid (req_valid), .req_we (req_we), .req_last (req_last),
        .req_addr (req_addr), .req_wdata (req_wdata),
        .req_ready (req_ready), .rd_valid (rd_valid), .rd_data (rd_data),
        .busy (busy), .owner_id (owner_id),
        .sram_write_enable (sram_write_enable),
        .sram_write_address (sram_write_address),
        .sram_write_data (sram_write_data),
        .sram_read_address (sram_read_address),
        .sram_read_data (sram_read_data)
    );

    always #5 clk = ~clk;

    // ---------------- SRAM environment model ----------------
    function automatic logic [31:0] base_val(input logic [7:0] a);
        return (a == 8'h20) ? 32'hDEADBEEF : {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    bit [31:0] s_mem [256];
    bit        s_wr  [256];
    always @(posedge clk) begin
        if (sram_write_enable) begin
            s_mem[sram_write_address[7:0]] <= sram_write_data;
            s_wr[sram_write_address[7:0]]  <= 1'b1;
        end
        sram_read_data <= s_wr[sram_read_address[7:0]] ? s_mem[sram_read_address[7:0]]
                                                       : base_val(sram_read_address[7:0]);
    end

    // ---------------- counters ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus driver state ----------------
    int        left  [N];
    int        idx   [N];
    int        base  [N];
    int        stall [N];
    bit        d_we  [N];
    bit        nolast[N];
    bit        single[N];
    bit [31:0] dbase [N];

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (left[i] > 0) && (stall[i] == 0);
            req_we[i]    = d_we[i];
            req_last[i]  = single[i] || ((left[i] == 1) && !nolast[i]);
            req_addr[i*AW +: AW]  = 16'((base[i] + idx[i]) & 255);
            req_wdata[i*DW +: DW] = dbase[i] + 32'(idx[i]);
        end
    endtask

    task automatic clear_drv();
        for (int i = 0; i < N; i++) begin
            left[i] = 0; idx[i] = 0; base[i] = 0; stall[i] = 0;
            d_we[i] = 1'b0; nolast[i] = 1'b0; single[i] = 1'b0; dbase[i] = '0;
        end
    endtask

    task automatic start(input int i, input int len, input bit we, input int b,
                         input bit [31:0] db);
        left[i] = len; idx[i] = 0; d_we[i] = we; base[i] = b; dbase[i] = db;
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit        m_busy = 1'b0;
    int        m_owner = 0, m_ptr = 0, m_cnt = 0, m_tag = 0;
    bit        m_pend = 1'b0;
    bit [31:0] m_pdata = '0;
    bit [15:0] m_hold = '0;
    bit [31:0] e_mem [256];
    bit        e_wr  [256];

    // DUT-observed grant log: owner and number of accepted beats per grant.
    int  g_own[$];
    int  g_beats[$];
    bit  prev_busy = 1'b0;
    bit  seen_dead = 1'b0;

    task automatic cycle(input string ph);
        bit          acc, we, last;
        logic [15:0] a;
        logic [31:0] wd;
        logic [N-1:0] e_ready, e_rdv;
        int          o;
        bit          found;
        drive();
        o    = m_owner;
        acc  = m_busy && req_valid[o];
        we   = req_we[o];
        last = req_last[o];
        a    = req_addr[o*AW +: AW];
        wd   = req_wdata[o*DW +: DW];
        e_ready = m_busy ? (4'b0001 << o) : 4'b0000;
        e_rdv   = m_pend ? (4'b0001 << m_tag) : 4'b0000;

        @(negedge clk);
        chk({ph, ":req_ready"}, 64'(req_ready), 64'(e_ready));
        chk({ph, ":busy"},      64'(busy),      64'(m_busy));
        chk({ph, ":owner_id"},  64'(owner_id),  m_busy ? 64'(o) : 64'd0);
        chk({ph, ":wr_en"},     64'(sram_write_enable), 64'(acc && we));
        chk({ph, ":wr_addr"},   64'(sram_write_address), (acc && we) ? 64'(a) : 64'd0);
        chk({ph, ":wr_data"},   64'(sram_write_data),    (acc && we) ? 64'(wd) : 64'd0);
        chk({ph, ":rd_addr"},   64'(sram_read_address),  (acc && !we) ? 64'(a) : 64'(m_hold));
        chk({ph, ":rd_valid"},  64'(rd_valid),  64'(e_rdv));
        chk({ph, ":rd_data"},   64'(rd_data),   m_pend ? 64'(m_pdata) : 64'd0);

        if (rd_valid === 4'b0010 && rd_data === 32'hDEADBEEF) seen_dead = 1'b1;
        if (busy === 1'b1 && !prev_busy) begin
            g_own.push_back(int'(owner_id));
            g_beats.push_back(0);
        end
        if (busy === 1'b1 && (req_ready & req_valid) != '0 && g_beats.size() > 0)
            g_beats[g_beats.size()-1]++;
        prev_busy = (busy === 1'b1);

        // Model state advance for the coming clock edge.
        if (acc && we) begin
            e_mem[a[7:0]] = wd;
            e_wr[a[7:0]]  = 1'b1;
        end
        if (reset) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
            m_pend = 0; m_tag = 0; m_hold = '0;
        end else begin
            m_pend = acc && !we;
            if (m_pend) begin
                m_tag   = o;
                m_pdata = e_wr[a[7:0]] ? e_mem[a[7:0]] : base_val(a[7:0]);
                m_hold  = a;
            end
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req_valid[(m_ptr + k) % N]) begin
                        found = 1'b1; m_busy = 1'b1; m_owner = (m_ptr + k) % N; m_cnt = 0;
                    end
                end
            end else if (acc) begin
                if (last || m_cnt == MB - 1) begin
                    m_busy = 1'b0; m_ptr = (o + 1) % N;
                end else begin
                    m_cnt++;
                end
            end
        end

        // Requester side: consume the beat if it was accepted.
        if (acc) begin
            left[o]--; idx[o]++;
        end
        for (int i = 0; i < N; i++) if (stall[i] > 0) stall[i]--;

        @(posedge clk);
        #1;
    endtask

    task automatic run(input string ph, input int n);
        for (int c = 0; c < n; c++) cycle(ph);
    endtask

    task automatic clear_log();
        g_own.delete();
        g_beats.delete();
    endtask

    task automatic pulse_reset(input string ph);
        reset = 1'b1;
        cycle(ph);
        reset = 1'b0;
    endtask

    initial begin
        int rc;
        clear_drv();
        reset = 1'b1;
        run("reset", 3);
        reset = 1'b0;

        // Single requester: three writes from req 2.
        clear_log();
        start(2, 3, 1'b1, 'h10, 32'hA);
        run("single", 8);
        chk("single:grants", 64'(g_own.size()), 64'd1);
        chk("single:owner",  g_own.size() > 0 ? 64'(g_own[0]) : 64'hFF, 64'd2);
        chk("single:beats",  g_beats.size() > 0 ? 64'(g_beats[0]) : 64'hFF, 64'd3);

        // Read return to req 1.
        seen_dead = 1'b0;
        start(1, 1, 1'b0, 'h20, 32'h0);
        run("read", 5);
        chk("read:return_seen", 64'(seen_dead), 64'd1);

        // Round-robin fairness with single-beat bursts from 0, 1, 3.
        pulse_reset("rst_rr");
        clear_log();
        for (int i = 0; i < N; i++) begin
            if (i != 2) begin
                start(i, 2, 1'b1, 'h30 + 8*i, 32'h100 * i);
                single[i] = 1'b1;
            end
        end
        run("fair", 14);
        chk("fair:grants", 64'(g_own.size()), 64'd6);
        for (int k = 0; k < 6; k++) begin
            int exp_o;
            exp_o = (k % 3 == 2) ? 3 : (k % 3);
            chk("fair:order", k < g_own.size() ? 64'(g_own[k]) : 64'hFF, 64'(exp_o));
        end
        clear_drv();

        // Forced release: req 0 never asserts last, req 2 waits.
        clear_log();
        start(0, 40, 1'b1, 'h80, 32'h5000);
        nolast[0] = 1'b1;
        start(2, 2, 1'b1, 'hC0, 32'h7000);
        run("force", 60);
        chk("force:own0",   g_own.size() > 2 ? 64'(g_own[0]) : 64'hFF, 64'd0);
        chk("force:beats0", g_beats.size() > 2 ? 64'(g_beats[0]) : 64'hFF, 64'd16);
        chk("force:own1",   g_own.size() > 2 ? 64'(g_own[1]) : 64'hFF, 64'd2);
        chk("force:own2",   g_own.size() > 2 ? 64'(g_own[2]) : 64'hFF, 64'd0);
        clear_drv();

        // Owner stall in the middle of a burst.
        pulse_reset("rst_stall");
        clear_log();
        start(3, 8, 1'b1, 'h50, 32'h9000);
        run("stall", 4);
        stall[3] = 3;
        run("stall", 12);
        chk("stall:grants", 64'(g_own.size()), 64'd1);
        chk("stall:beats",  g_beats.size() > 0 ? 64'(g_beats[0]) : 64'hFF, 64'd8);

        // Reset during beat 5 of a read burst; ptr must restart at 0.
        start(0, 1, 1'b1, 'h60, 32'hAAAA);
        run("pre_rst", 3);
        start(1, 10, 1'b0, 'h40, 32'h0);
        rc = 0;
        while (idx[1] < 4 && rc < 20) begin
            cycle("rdburst");
            rc++;
        end
        chk("rdburst:reached_beat5", 64'(idx[1]), 64'd4);
        reset = 1'b1;
        cycle("midrst");
        reset = 1'b0;
        clear_drv();
        clear_log();
        start(0, 1, 1'b1, 'h70, 32'hB0);
        start(3, 1, 1'b1, 'h78, 32'hB3);
        run("postrst", 6);
        chk("postrst:first_owner", g_own.size() > 0 ? 64'(g_own[0]) : 64'hFF, 64'd0);
        clear_drv();

        // Randomized traffic.
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (left[i] == 0 && ($urandom % 4) == 0)
                    start(i, int'($urandom_range(1, 40)), 1'($urandom),
                          int'($urandom_range(0, 255)), $urandom);
                if (stall[i] == 0 && ($urandom % 10) == 0)
                    stall[i] = int'($urandom_range(1, 3));
            end
            reset = (($urandom % 150) == 0);
            cycle("rand");
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_scratchpad_rr_arbiter
`default_nettype wire
